alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_seq_pkg.sv | 82 ++++++++
 rtl/alu_seq_perf.sv | 39 +++
 rtl/alu_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and decode helpers for the ALU sequencer.
// FSM state enum, opcode enum and compare-flag encodings live here so the
// top level and any checker agree on one set of names.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WB     = 3'd3,
      ST_HALTED = 3'd4
   } seq_state_e;

   typedef enum logic [3:0] {
      OP_AND  = 4'd0,
      OP_OR   = 4'd1,
      OP_ADD  = 4'd2,
      OP_SUB  = 4'd3,
      OP_ADDI = 4'd4,
      OP_LDI  = 4'd5,
      OP_LDR  = 4'd6,
      OP_CMP  = 4'd7,
      OP_INC  = 4'd8,
      OP_JMP  = 4'd9,
      OP_BEQ  = 4'd10,
      OP_BGT  = 4'd11,
      OP_BLT  = 4'd12,
      OP_XOR  = 4'd13,
      OP_RSV  = 4'd14,
      OP_HALT = 4'd15
   } opcode_e;

   // Compare flag encodings held in cmp_q
   localparam logic [1:0] CMP_NONE = 2'b11;
   localparam logic [1:0] CMP_EQ   = 2'b10;
   localparam logic [1:0] CMP_GT   = 2'b01;
   localparam logic [1:0] CMP_LT   = 2'b00;

   // Ops that consume and produce the carry flag
   function automatic logic uses_carry(input opcode_e op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_INC: r = 1'b1;
         default:                         r = 1'b0;
      endcase
      return r;
   endfunction

   // Ops whose result is written back to the accumulator R0
   function automatic logic writes_acc(input opcode_e op);
      logic r;
      case (op)
         OP_AND, OP_OR, OP_ADD, OP_SUB, OP_ADDI, OP_LDR, OP_INC: r = 1'b1;
         default:                                               r = 1'b0;
      endcase
      return r;
   endfunction

   // Ops whose result is written back to the register named by the r field
   function automatic logic writes_reg(input opcode_e op);
      logic r;
      case (op)
         OP_LDI, OP_XOR: r = 1'b1;
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

   // Branch decision from the opcode and the stored compare flags
   function automatic logic branch_taken(input opcode_e op, input logic [1:0] cmp);
      logic r;
      case (op)
         OP_JMP:  r = 1'b1;
         OP_BEQ:  r = (cmp == CMP_EQ);
         OP_BGT:  r = (cmp == CMP_GT);
         OP_BLT:  r = (cmp == CMP_LT);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_seq_perf.sv
// Saturating performance counters for the ALU sequencer: completed
// instructions and busy cycles. Only instantiated when the top is built
// with ALU_SEQUENCER_PERF_EN defined.
module alu_seq_perf #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         done,
   input  logic         busy,
   output logic [W-1:0] perf_instr,
   output logic [W-1:0] perf_cycles
);

   logic [W-1:0] instr_cnt_r;
   logic [W-1:0] cycle_cnt_r;

   // Count completion pulses, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_cnt_r <= {W{1'b0}};
      end else if (done && (instr_cnt_r != {W{1'b1}})) begin
         instr_cnt_r <= instr_cnt_r + {{(W-1){1'b0}}, 1'b1};
      end
   end

   // Count cycles spent working on an instruction, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_r <= {W{1'b0}};
      end else if (busy && (cycle_cnt_r != {W{1'b1}})) begin
         cycle_cnt_r <= cycle_cnt_r + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign perf_instr  = instr_cnt_r;
   assign perf_cycles = cycle_cnt_r;

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one instruction at a time and walks it through
// READ (register-file address), EXEC (drive ALU), WB (write/branch/done
// pulses), then returns to IDLE or parks in HALTED on the halt opcode.
// All drive towards the ALU, register file and branch unit is registered.
// Optional build macro ALU_SEQUENCER_PERF_EN adds perf_instr/perf_cycles.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned INSTR_W = 9,
   parameter int unsigned PERF_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instr,
   output logic               instr_ready,
   output logic [3:0]         rf_raddr,
   input  logic [7:0]         rf_rdata,
   input  logic [7:0]         acc_rdata,
   output logic [3:0]         alu_op,
   output logic [7:0]         alu_a,
   output logic [7:0]         alu_b,
   output logic [2:0]         alu_imm,
   output logic               alu_sc,
   input  logic [7:0]         alu_result,
   input  logic               alu_carry,
   input  logic [1:0]         alu_cmp,
   input  logic               alu_halt,
   output logic               rf_we,
   output logic [3:0]         rf_waddr,
   output logic [7:0]         rf_wdata,
   output logic               br_taken,
   output logic [3:0]         br_offset,
   output logic               done,
   output logic               illegal,
`ifdef ALU_SEQUENCER_PERF_EN
   output logic [PERF_W-1:0]  perf_instr,
   output logic [PERF_W-1:0]  perf_cycles,
`endif
   output logic               halted
);

   seq_state_e         state_r;
   seq_state_e         state_nxt_s;
   logic [INSTR_W-1:0] instr_r;
   opcode_e            op_s;
   logic [3:0]         r_field_s;
   logic               accept_s;

   logic               instr_ready_r;
   logic [3:0]         rf_raddr_r;
   logic [3:0]         alu_op_r;
   logic [7:0]         alu_a_r;
   logic [7:0]         alu_b_r;
   logic [2:0]         alu_imm_r;
   logic               alu_sc_r;
   logic               carry_q_r;
   logic [1:0]         cmp_q_r;
   logic               rf_we_r;
   logic [3:0]         rf_waddr_r;
   logic [7:0]         rf_wdata_r;
   logic               br_taken_r;
   logic [3:0]         br_offset_r;
   logic               done_r;
   logic               illegal_r;
   logic               halted_r;

   assign op_s      = opcode_e'(instr_r[8:5]);
   assign r_field_s = instr_r[4:1];
   assign accept_s  = instr_valid && instr_ready_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; halt decision comes from the opcode, not alu_halt
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ:   state_nxt_s = ST_EXEC;
         ST_EXEC:   state_nxt_s = ST_WB;
         ST_WB: begin
            if (op_s == OP_HALT) begin
               state_nxt_s = ST_HALTED;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HALTED: state_nxt_s = ST_HALTED;
         default:   state_nxt_s = ST_IDLE;
      endcase
   end

   // Ready is high exactly while the FSM sits in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_ready_r <= 1'b1;
      end else begin
         instr_ready_r <= (state_nxt_s == ST_IDLE);
      end
   end

   // Latch the instruction and its read index on acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_r    <= {INSTR_W{1'b0}};
         rf_raddr_r <= 4'd0;
      end else if (accept_s) begin
         instr_r    <= instr;
         rf_raddr_r <= instr[4:1];
      end
   end

   // Capture ALU operands during READ; opcode is only non-zero through EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op_r  <= 4'd0;
         alu_a_r   <= 8'd0;
         alu_b_r   <= 8'd0;
         alu_imm_r <= 3'd0;
         alu_sc_r  <= 1'b0;
      end else if (state_r == ST_READ) begin
         alu_op_r  <= op_s;
         alu_a_r   <= (op_s == OP_LDR) ? rf_rdata : acc_rdata;
         alu_b_r   <= rf_rdata;
         alu_imm_r <= instr_r[3:1];
         alu_sc_r  <= instr_r[0] & carry_q_r & uses_carry(op_s);
      end else if (state_r == ST_EXEC) begin
         alu_op_r  <= 4'd0;
         alu_sc_r  <= 1'b0;
      end
   end

   // Capture ALU result and update flags at the end of EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wdata_r <= 8'd0;
         carry_q_r  <= 1'b0;
         cmp_q_r    <= CMP_NONE;
      end else if (state_r == ST_EXEC) begin
         rf_wdata_r <= alu_result;
         if (uses_carry(op_s)) begin
            carry_q_r <= alu_carry;
         end
         if (op_s == OP_CMP) begin
            cmp_q_r <= alu_cmp;
         end
      end
   end

   // Write-back, branch, done and illegal pulses live for the WB cycle only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_r     <= 1'b0;
         rf_waddr_r  <= 4'd0;
         br_taken_r  <= 1'b0;
         br_offset_r <= 4'd0;
         done_r      <= 1'b0;
         illegal_r   <= 1'b0;
      end else if (state_r == ST_EXEC) begin
         rf_we_r     <= writes_acc(op_s) | writes_reg(op_s);
         rf_waddr_r  <= writes_reg(op_s) ? r_field_s : 4'd0;
         br_taken_r  <= branch_taken(op_s, cmp_q_r);
         br_offset_r <= r_field_s;
         done_r      <= 1'b1;
         illegal_r   <= (op_s == OP_RSV);
      end else if (state_r == ST_WB) begin
         rf_we_r     <= 1'b0;
         br_taken_r  <= 1'b0;
         done_r      <= 1'b0;
         illegal_r   <= 1'b0;
      end
   end

   // Sticky halt flag, only cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted_r <= 1'b0;
      end else if ((state_r == ST_WB) && (op_s == OP_HALT)) begin
         halted_r <= 1'b1;
      end
   end

   assign instr_ready = instr_ready_r;
   assign rf_raddr    = rf_raddr_r;
   assign alu_op      = alu_op_r;
   assign alu_a       = alu_a_r;
   assign alu_b       = alu_b_r;
   assign alu_imm     = alu_imm_r;
   assign alu_sc      = alu_sc_r;
   assign rf_we       = rf_we_r;
   assign rf_waddr    = rf_waddr_r;
   assign rf_wdata    = rf_wdata_r;
   assign br_taken    = br_taken_r;
   assign br_offset   = br_offset_r;
   assign done        = done_r;
   assign illegal     = illegal_r;
   assign halted      = halted_r;

   // The ALU's own halt indication is deliberately ignored
   logic alu_halt_unused_s;
   assign alu_halt_unused_s = alu_halt;

`ifdef ALU_SEQUENCER_PERF_EN
   logic busy_s;
   assign busy_s = (state_r == ST_READ) || (state_r == ST_EXEC) || (state_r == ST_WB);

   alu_seq_perf #(
      .W (PERF_W)
   ) u_perf (
      .clk         (clk),
      .rst_n       (rst_n),
      .done        (done_r),
      .busy        (busy_s),
      .perf_instr  (perf_instr),
      .perf_cycles (perf_cycles)
   );
`else
   localparam int unsigned perf_w_unused = PERF_W;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. The bench plays register file and
// ALU, keeps a transaction-level model of what each accepted instruction
// must do, and compares the DUT against it on every cycle, alongside a set
// of hand-computed expectations for specific instructions.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid;
   logic [8:0] instr;
   logic       instr_ready;
   logic [3:0] rf_raddr;
   logic [7:0] rf_rdata, acc_rdata;
   logic [3:0] alu_op;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_imm;
   logic       alu_sc;
   logic [7:0] alu_result;
   logic       alu_carry;
   logic [1:0] alu_cmp;
   logic       alu_halt;
   logic       rf_we;
   logic [3:0] rf_waddr;
   logic [7:0] rf_wdata;
   logic       br_taken;
   logic [3:0] br_offset;
   logic       done, illegal, halted;
`ifdef ALU_SEQUENCER_PERF_EN
   logic [15:0] perf_instr, perf_cycles;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.INSTR_W(9), .PERF_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
      .acc_rdata(acc_rdata), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_imm(alu_imm), .alu_sc(alu_sc), .alu_result(alu_result),
      .alu_carry(alu_carry), .alu_cmp(alu_cmp), .alu_halt(alu_halt),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .br_taken(br_taken), .br_offset(br_offset), .done(done),
      .illegal(illegal),
`ifdef ALU_SEQUENCER_PERF_EN
      .perf_instr(perf_instr), .perf_cycles(perf_cycles),
`endif
      .halted(halted)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ALU: {cmp[1:0], carry, result[7:0]}
   function automatic logic [10:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [2:0] imm,
                                         input logic sc);
      logic [8:0] s;
      logic [1:0] cm;
      s  = 9'd0;
      cm = 2'b11;
      case (op)
         4'd0:  s = {1'b0, a & b};
         4'd1:  s = {1'b0, a | b};
         4'd2:  s = {1'b0, a} + {1'b0, b} + {8'd0, sc};
         4'd3:  s = {1'b0, a} - {1'b0, b} - {8'd0, sc};
         4'd4:  s = {1'b0, a} + {6'd0, imm} + {8'd0, sc};
         4'd5:  s = {6'd0, imm};
         4'd6:  s = {1'b0, a};
         4'd7:  cm = (a == b) ? 2'b10 : ((a > b) ? 2'b01 : 2'b00);
         4'd8:  s = {1'b0, a} + 9'd1 + {8'd0, sc};
         4'd13: s = {1'b0, a ^ b};
         default: s = 9'd0;
      endcase
      return {cm, s};
   endfunction

   // Bench register file and ALU
   logic [7:0] regs [16] = '{8'd5, 8'd250, 8'd100, 8'd7, 8'd0, 8'd15, 8'd0, 8'd0,
                             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   assign rf_rdata  = regs[rf_raddr];
   assign acc_rdata = regs[0];
   assign {alu_cmp, alu_carry, alu_result} = alu_fn(alu_op, alu_a, alu_b, alu_imm, alu_sc);
   assign alu_halt  = (alu_op == 4'd15);

   always @(posedge clk) begin
      if (rf_we) regs[rf_waddr] <= rf_wdata;
   end

   // ---------------- transaction-level model ----------------
   typedef struct packed {
      logic [3:0] op;
      logic [3:0] r;
      logic [2:0] imm;
      logic [7:0] a;
      logic [7:0] b;
      logic       sc;
      logic [7:0] res;
      logic       cy;
      logic [1:0] cm;
      logic       we;
      logic [3:0] waddr;
      logic       br;
      logic       ill;
   } exp_t;

   function automatic exp_t predict(input logic [8:0] ins, input logic [7:0] acc,
                                    input logic [7:0] rv, input logic cy,
                                    input logic [1:0] cmp);
      exp_t e;
      logic [10:0] o;
      e.op    = ins[8:5];
      e.r     = ins[4:1];
      e.imm   = ins[3:1];
      e.a     = (e.op == 4'd6) ? rv : acc;
      e.b     = rv;
      e.sc    = ins[0] && cy && (e.op inside {4'd2, 4'd3, 4'd4, 4'd8});
      o       = alu_fn(e.op, e.a, e.b, e.imm, e.sc);
      e.res   = o[7:0];
      e.cy    = o[8];
      e.cm    = o[10:9];
      e.we    = e.op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd13};
      e.waddr = (e.op inside {4'd5, 4'd13}) ? e.r : 4'd0;
      case (e.op)
         4'd9:    e.br = 1'b1;
         4'd10:   e.br = (cmp == 2'b10);
         4'd11:   e.br = (cmp == 2'b01);
         4'd12:   e.br = (cmp == 2'b00);
         default: e.br = 1'b0;
      endcase
      e.ill = (e.op == 4'd14);
      return e;
   endfunction

   logic [7:0] mregs [16] = '{8'd5, 8'd250, 8'd100, 8'd7, 8'd0, 8'd15, 8'd0, 8'd0,
                              8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   int         m_pos;      // cycles since acceptance: 0 none, 1..3 in flight
   logic       m_carry;
   logic [1:0] m_cmp;
   logic       m_halted;
   exp_t       m_e;

   // Model: instruction occupies the three cycles after its accept edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos    <= 0;
         m_carry  <= 1'b0;
         m_cmp    <= 2'b11;
         m_halted <= 1'b0;
      end else if (m_pos == 0) begin
         if (!m_halted && instr_valid) begin
            m_e   <= predict(instr, mregs[0], mregs[instr[4:1]], m_carry, m_cmp);
            m_pos <= 1;
         end
      end else if (m_pos < 3) begin
         m_pos <= m_pos + 1;
      end else begin
         m_pos <= 0;
         if (m_e.we) mregs[m_e.waddr] <= m_e.res;
         if (m_e.op inside {4'd2, 4'd3, 4'd4, 4'd8}) m_carry <= m_e.cy;
         if (m_e.op == 4'd7) m_cmp <= m_e.cm;
         if (m_e.op == 4'd15) m_halted <= 1'b1;
      end
   end

   // Compare DUT against the model every cycle out of reset
   always @(negedge clk) begin
      if (rst_n) begin
         check("instr_ready", instr_ready, (m_pos == 0) && !m_halted);
         check("halted", halted, m_halted);
         check("alu_op", alu_op, (m_pos == 2) ? m_e.op : 4'd0);
         check("rf_we", rf_we, (m_pos == 3) && m_e.we);
         check("br_taken", br_taken, (m_pos == 3) && m_e.br);
         check("done", done, m_pos == 3);
         check("illegal", illegal, (m_pos == 3) && m_e.ill);
         if (m_pos == 1) check("rf_raddr", rf_raddr, m_e.r);
         if (m_pos == 2) begin
            check("alu_a", alu_a, m_e.a);
            check("alu_b", alu_b, m_e.b);
            check("alu_imm", alu_imm, m_e.imm);
            check("alu_sc", alu_sc, m_e.sc);
         end
         if ((m_pos == 3) && m_e.we) begin
            check("rf_waddr", rf_waddr, m_e.waddr);
            check("rf_wdata", rf_wdata, m_e.res);
         end
         if ((m_pos == 3) && m_e.br) check("br_offset", br_offset, m_e.r);
      end
   end

   // ---------------- directed stimulus ----------------
   logic       s_sc, s_we, s_br, s_done, s_ill;
   logic [7:0] s_a, s_wdata;
   logic [3:0] s_waddr, s_boff;

   // Issue one instruction in an idle cycle and snapshot EXEC and WB outputs
   task automatic run(input logic [8:0] ins, input bit hold);
      @(negedge clk);
      instr = ins;
      instr_valid = 1'b1;
      @(negedge clk);
      if (!hold) instr_valid = 1'b0;
      @(negedge clk);
      s_sc = alu_sc;
      s_a  = alu_a;
      @(negedge clk);
      s_we = rf_we; s_waddr = rf_waddr; s_wdata = rf_wdata;
      s_br = br_taken; s_boff = br_offset; s_done = done; s_ill = illegal;
   endtask

   function automatic logic [8:0] mk(input int op, input int r, input int c);
      logic [3:0] o4, r4;
      o4 = op[3:0];
      r4 = r[3:0];
      return {o4, r4, c[0]};
   endfunction

   initial begin
      rst_n = 1'b0;
      instr_valid = 1'b0;
      instr = 9'd0;
      repeat (3) @(negedge clk);
      check("rst halted", halted, 0);
      check("rst rf_we", rf_we, 0);
      check("rst done", done, 0);
      check("rst alu_op", alu_op, 0);
      check("rst br_taken", br_taken, 0);
      check("rst illegal", illegal, 0);
      rst_n = 1'b1;
      #1 check("ready after reset", instr_ready, 1);

      run(mk(12, 1, 0), 1'b0);            // cmp_q still none
      check("blt before cmp br", s_br, 0);
      check("blt done", s_done, 1);
      run(9'b0010_0011_0, 1'b0);          // 5 + 7
      check("add we", s_we, 1);
      check("add waddr", s_waddr, 0);
      check("add wdata", s_wdata, 12);
      check("add done", s_done, 1);
      run(mk(2, 1, 0), 1'b0);             // 12 + 250 -> 6, carry
      check("add carry wdata", s_wdata, 6);
      run(mk(2, 3, 1), 1'b0);             // 6 + 7 + 1
      check("adc sc=1", s_sc, 1);
      check("adc wdata", s_wdata, 14);
      run(mk(2, 1, 0), 1'b0);             // 14 + 250 -> 8, carry
      run(mk(2, 3, 0), 1'b0);             // c=0 ignores carry
      check("add sc=0", s_sc, 0);
      check("add nc wdata", s_wdata, 15);
      run(mk(7, 5, 0), 1'b0);             // 15 == 15
      check("cmp no write", s_we, 0);
      run(mk(10, 6, 0), 1'b0);
      check("beq taken", s_br, 1);
      check("beq offset", s_boff, 6);
      run(mk(11, 6, 0), 1'b0);
      check("bgt not taken", s_br, 0);
      run(mk(13, 2, 0), 1'b0);            // 100 ^ 15
      check("xor waddr", s_waddr, 2);
      check("xor wdata", s_wdata, 107);
      run(mk(5, 4, 0), 1'b0);             // imm = 3'b100
      check("ldi waddr", s_waddr, 4);
      check("ldi wdata", s_wdata, 4);
      run(mk(6, 4, 0), 1'b0);
      check("ldr alu_a", s_a, 4);
      run(mk(14, 0, 0), 1'b0);
      check("rsv illegal", s_ill, 1);
      check("rsv no write", s_we, 0);
      check("rsv done", s_done, 1);
      run(mk(9, 9, 0), 1'b0);
      check("jmp offset", s_boff, 9);
      run(mk(7, 2, 0), 1'b0);             // 4 < 107
      run(mk(12, 3, 0), 1'b0);
      check("blt taken", s_br, 1);
      run(mk(7, 7, 0), 1'b0);             // 4 > 0
      run(mk(11, 8, 0), 1'b0);
      check("bgt taken", s_br, 1);
      check("bgt offset", s_boff, 8);

      // Reset in the middle of EXEC of a writing instruction
      @(negedge clk);
      instr = mk(2, 3, 0);
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      check("pre-reset alu_op", alu_op, 2);
      #2 rst_n = 1'b0;
      #1;
      check("abort rf_we", rf_we, 0);
      check("abort alu_op", alu_op, 0);
      check("abort ready", instr_ready, 1);
      @(negedge clk);
      check("abort no we", rf_we, 0);
      check("abort no done", done, 0);
      rst_n = 1'b1;
      #1 check("ready after release", instr_ready, 1);
      check("acc unchanged", regs[0], 4);
      run(mk(11, 7, 0), 1'b0);            // cmp cleared by reset
      check("bgt after reset", s_br, 0);

      // Halt with instr_valid held high afterwards
      run(mk(15, 0, 0), 1'b1);
      check("halt done", s_done, 1);
      check("halt no write", s_we, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("halted sticky", halted, 1);
         check("halted not ready", instr_ready, 0);
         check("halted done quiet", done, 0);
      end
      instr_valid = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
